// File: rtl/tft_client_sequencer_if.sv
// Client-side bus of the TFT client sequencer: per-client handshake lines
// in, one-hot enables out, and the muxed stream towards the SPI transmitter.
interface tft_client_sequencer_if #(
   parameter int NUM_CLIENTS = 3,
   parameter int DATA_W      = 8
);
   logic [NUM_CLIENTS-1:0]        client_busy;
   logic [NUM_CLIENTS*DATA_W-1:0] client_data;
   logic [NUM_CLIENTS-1:0]        client_dc;
   logic [NUM_CLIENTS-1:0]        client_transmit;
   logic [NUM_CLIENTS-1:0]        client_skip;
   logic [NUM_CLIENTS-1:0]        client_enable;
   logic [DATA_W-1:0]             spi_data;
   logic                          spi_dc;
   logic                          spi_transmit;

   modport master (
      input  client_busy, client_data, client_dc, client_transmit, client_skip,
      output client_enable, spi_data, spi_dc, spi_transmit
   );

   modport slave (
      output client_busy, client_data, client_dc, client_transmit, client_skip,
      input  client_enable, spi_data, spi_dc, spi_transmit
   );
endinterface

// File: rtl/tft_client_sequencer.sv
// Sequences NUM_CLIENTS drawing clients onto one SPI transmitter: a one-shot
// prefix after reset, then the remaining clients loop with skip/hold/timeout.
module tft_client_sequencer #(
   parameter int NUM_CLIENTS   = 3,
   parameter int ONESHOT_COUNT = 1,
   parameter int DATA_W        = 8,
   parameter int ARM_TIMEOUT   = 4,
   localparam int IDX_W        = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          start_ready_i,
   input  logic                          hold_i,
   tft_client_sequencer_if.master        bus,
   output logic [IDX_W-1:0]              active_idx_o,
   output logic                          frame_done_o,
   output logic [15:0]                   frame_count_o
);

   typedef enum logic [2:0] {
      ST_WAIT_START = 3'd0,
      ST_SELECT     = 3'd1,
      ST_ARM        = 3'd2,
      ST_RUN        = 3'd3,
      ST_ADVANCE    = 3'd4,
      ST_DONE       = 3'd5
   } state_e;

   localparam logic [NUM_CLIENTS-1:0] ONE_HOT0 = {{(NUM_CLIENTS-1){1'b0}}, 1'b1};

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [NUM_CLIENTS-1:0] enable_q, enable_d;
   logic [7:0]             cnt_q, cnt_d;
   logic                   frame_done_q, frame_done_d;
   logic [15:0]            frame_count_q, frame_count_d;

   logic                   busy_sel_s, skip_sel_s;
   logic [DATA_W-1:0]      spi_data_s;
   logic                   spi_dc_s, spi_transmit_s;
   logic [IDX_W-1:0]       adv_idx_s;
   state_e                 adv_state_s;
   logic                   adv_pulse_s, adv_count_s;

   // Pick the selected client's busy/skip and mux its stream only while enabled
   always_comb begin
      busy_sel_s     = 1'b0;
      skip_sel_s     = 1'b0;
      spi_data_s     = {DATA_W{1'b0}};
      spi_dc_s       = 1'b0;
      spi_transmit_s = 1'b0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         busy_sel_s     = busy_sel_s | ((idx_q == IDX_W'(i)) & bus.client_busy[i]);
         skip_sel_s     = skip_sel_s | ((idx_q == IDX_W'(i)) & bus.client_skip[i]);
         spi_data_s     = spi_data_s | ({DATA_W{(idx_q == IDX_W'(i)) & enable_q[i]}}
                                        & bus.client_data[i*DATA_W +: DATA_W]);
         spi_dc_s       = spi_dc_s | ((idx_q == IDX_W'(i)) & enable_q[i] & bus.client_dc[i]);
         spi_transmit_s = spi_transmit_s
                          | ((idx_q == IDX_W'(i)) & enable_q[i] & bus.client_transmit[i]);
      end
   end

   // Advance rule shared by a skipped selection and a finished client
   always_comb begin
      if (idx_q != IDX_W'(NUM_CLIENTS - 1)) begin
         adv_idx_s   = idx_q + IDX_W'(1);
         adv_state_s = ST_SELECT;
         adv_pulse_s = 1'b0;
         adv_count_s = 1'b0;
      end else if (ONESHOT_COUNT < NUM_CLIENTS) begin
         adv_idx_s   = IDX_W'(ONESHOT_COUNT);
         adv_state_s = ST_SELECT;
         adv_pulse_s = 1'b1;
         adv_count_s = 1'b1;
      end else begin
         adv_idx_s   = idx_q;
         adv_state_s = ST_DONE;
         adv_pulse_s = 1'b1;
         adv_count_s = 1'b0;
      end
   end

   // Next-state logic of the sequencing FSM
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      enable_d      = enable_q;
      cnt_d         = cnt_q;
      frame_done_d  = 1'b0;
      frame_count_d = frame_count_q;
      case (state_q)
         ST_WAIT_START: begin
            if (start_ready_i) begin
               state_d = ST_SELECT;
               idx_d   = {IDX_W{1'b0}};
            end else begin
               state_d = ST_WAIT_START;
            end
         end
         ST_SELECT: begin
            if (hold_i) begin
               state_d = ST_SELECT;
            end else if (skip_sel_s) begin
               state_d       = adv_state_s;
               idx_d         = adv_idx_s;
               frame_done_d  = adv_pulse_s;
               frame_count_d = frame_count_q + 16'(adv_count_s);
            end else begin
               enable_d = ONE_HOT0 << idx_q;
               cnt_d    = 8'(ARM_TIMEOUT);
               state_d  = ST_ARM;
            end
         end
         ST_ARM: begin
            if (busy_sel_s) begin
               state_d = ST_RUN;
            end else if (cnt_q <= 8'd1) begin
               // A client that never answers is treated as complete
               cnt_d    = 8'd0;
               enable_d = {NUM_CLIENTS{1'b0}};
               state_d  = ST_ADVANCE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_RUN: begin
            if (!busy_sel_s) begin
               enable_d = {NUM_CLIENTS{1'b0}};
               state_d  = ST_ADVANCE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_ADVANCE: begin
            state_d       = adv_state_s;
            idx_d         = adv_idx_s;
            frame_done_d  = adv_pulse_s;
            frame_count_d = frame_count_q + 16'(adv_count_s);
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d  = ST_WAIT_START;
            enable_d = {NUM_CLIENTS{1'b0}};
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= ST_WAIT_START;
         idx_q         <= {IDX_W{1'b0}};
         enable_q      <= {NUM_CLIENTS{1'b0}};
         cnt_q         <= 8'd0;
         frame_done_q  <= 1'b0;
         frame_count_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         enable_q      <= enable_d;
         cnt_q         <= cnt_d;
         frame_done_q  <= frame_done_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign bus.client_enable = enable_q;
   assign bus.spi_data      = spi_data_s;
   assign bus.spi_dc        = spi_dc_s;
   assign bus.spi_transmit  = spi_transmit_s;
   assign active_idx_o      = idx_q;
   assign frame_done_o      = frame_done_q;
   assign frame_count_o     = frame_count_q;

endmodule

// File: tb/tb_tft_client_sequencer.sv
// Bench for tft_client_sequencer: a looping N=3/OS=1 instance and a one-shot
// N=2/OS=2 instance driven by behavioural clients, checked against enable episodes.
module tb_tft_client_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start_ready, hold_a, hold_b;
   logic [2:0]  skip_a, silent_a, busy_a, en_last_a, dc_a;
   logic [1:0]  skip_b, busy_b, en_last_b, dc_b;
   int          cnt_a [3];
   int          cnt_b [2];
   bit          done_a [3];
   bit          done_b [2];
   logic [1:0]  idx_a;
   logic        idx_b, fd_a, fd_b;
   logic [15:0] fc_a, fc_b;

   tft_client_sequencer_if #(.NUM_CLIENTS(3), .DATA_W(8)) ia ();
   tft_client_sequencer_if #(.NUM_CLIENTS(2), .DATA_W(8)) ib ();

   assign ia.client_busy     = busy_a;
   assign ia.client_transmit = busy_a;
   assign ia.client_dc       = dc_a;
   assign ia.client_data     = {8'hA2, 8'hA1, 8'hA0};
   assign ia.client_skip     = skip_a;
   assign ib.client_busy     = busy_b;
   assign ib.client_transmit = busy_b;
   assign ib.client_dc       = dc_b;
   assign ib.client_data     = {8'hB1, 8'hB0};
   assign ib.client_skip     = skip_b;

   tft_client_sequencer #(.NUM_CLIENTS(3), .ONESHOT_COUNT(1), .DATA_W(8), .ARM_TIMEOUT(4)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .start_ready_i(start_ready), .hold_i(hold_a),
      .bus(ia), .active_idx_o(idx_a), .frame_done_o(fd_a), .frame_count_o(fc_a));

   tft_client_sequencer #(.NUM_CLIENTS(2), .ONESHOT_COUNT(2), .DATA_W(8), .ARM_TIMEOUT(4)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .start_ready_i(start_ready), .hold_i(hold_b),
      .bus(ib), .active_idx_o(idx_b), .frame_done_o(fd_b), .frame_count_o(fc_b));

   typedef struct { int scen; logic [2:0] pat; int len; int gap; } ep_t;
   typedef struct { logic [2:0] pat; int len; int gap; } obs_t;

   ep_t  vec [16];
   obs_t obs_a [$];
   obs_t obs_b [$];
   int   checks = 0, failures = 0, cyc = 0;
   int   st_a, st_b, gap_a, gap_b, drop_a, drop_b, fdn_a, fdn_b, tx_c1_a;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      logic [9:0] exp_a, exp_b;
      @(posedge clk);
      #1;
      cyc++;
      exp_a = 10'd0;
      for (int i = 0; i < 3; i++)
         if (ia.client_enable == (3'b001 << i)) exp_a = {8'hA0 + 8'(i), dc_a[i], busy_a[i]};
      chk("mux_a", int'({ia.spi_data, ia.spi_dc, ia.spi_transmit}), int'(exp_a));
      exp_b = 10'd0;
      for (int i = 0; i < 2; i++)
         if (ib.client_enable == (2'b01 << i)) exp_b = {8'hB0 + 8'(i), dc_b[i], busy_b[i]};
      chk("mux_b", int'({ib.spi_data, ib.spi_dc, ib.spi_transmit}), int'(exp_b));
      // episode monitors
      if (ia.client_enable != 3'b000 && en_last_a == 3'b000) begin st_a = cyc; gap_a = cyc - drop_a; end
      if (ia.client_enable == 3'b000 && en_last_a != 3'b000) begin
         obs_a.push_back('{pat: en_last_a, len: cyc - st_a, gap: gap_a});
         drop_a = cyc;
      end
      if (ib.client_enable != 2'b00 && en_last_b == 2'b00) begin st_b = cyc; gap_b = cyc - drop_b; end
      if (ib.client_enable == 2'b00 && en_last_b != 2'b00) begin
         obs_b.push_back('{pat: {1'b0, en_last_b}, len: cyc - st_b, gap: gap_b});
         drop_b = cyc;
      end
      if (fd_a) fdn_a++;
      if (fd_b) fdn_b++;
      if (ia.client_enable == 3'b010 && ia.spi_transmit) tx_c1_a++;
      // clients: busy one cycle after enable, held five cycles
      for (int i = 0; i < 3; i++) begin
         if (en_last_a[i] && !done_a[i] && !silent_a[i]) begin
            if (cnt_a[i] < 5) begin busy_a[i] = 1'b1; cnt_a[i]++; end
            else begin busy_a[i] = 1'b0; done_a[i] = 1'b1; end
         end else if (!en_last_a[i]) begin
            busy_a[i] = 1'b0; cnt_a[i] = 0; done_a[i] = 1'b0;
         end
      end
      for (int i = 0; i < 2; i++) begin
         if (en_last_b[i] && !done_b[i]) begin
            if (cnt_b[i] < 5) begin busy_b[i] = 1'b1; cnt_b[i]++; end
            else begin busy_b[i] = 1'b0; done_b[i] = 1'b1; end
         end else if (!en_last_b[i]) begin
            busy_b[i] = 1'b0; cnt_b[i] = 0; done_b[i] = 1'b0;
         end
      end
      en_last_a = ia.client_enable;
      en_last_b = ib.client_enable;
   endtask

   task automatic reset_all();
      @(negedge clk);
      rst_n = 1'b0;
      hold_a = 1'b0;
      start_ready = 1'b1;
      step();
      step();
      chk("rst_en_a", int'(ia.client_enable), 0);
      chk("rst_idx_a", int'(idx_a), 0);
      chk("rst_fd_a", int'(fd_a), 0);
      chk("rst_fc_a", int'(fc_a), 0);
      chk("rst_en_b", int'(ib.client_enable), 0);
      chk("rst_fc_b", int'(fc_b), 0);
      @(negedge clk);
      rst_n = 1'b1;
      obs_a.delete();
      obs_b.delete();
      fdn_a = 0; fdn_b = 0; tx_c1_a = 0;
      drop_a = cyc; drop_b = cyc;
   endtask

   task automatic wait_obs(input bit on_b, input int n, input string name);
      int k = 0;
      while (((on_b ? obs_b.size() : obs_a.size()) < n) && k < 400) begin
         step();
         k++;
      end
      chk(name, int'((on_b ? obs_b.size() : obs_a.size()) >= n), 1);
   endtask

   task automatic wait_en_a(input logic [2:0] pat, input string name);
      int k = 0;
      while (ia.client_enable != pat && k < 200) begin
         step();
         k++;
      end
      chk(name, int'(ia.client_enable), int'(pat));
   endtask

   task automatic check_eps(input int s, input obs_t q [$]);
      int j = 0;
      for (int k = 0; k < 16; k++) begin
         if (vec[k].scen == s) begin
            if (j < q.size()) begin
               chk($sformatf("s%0d_ep%0d_pat", s, j), int'(q[j].pat), int'(vec[k].pat));
               chk($sformatf("s%0d_ep%0d_len", s, j), q[j].len, vec[k].len);
               if (vec[k].gap >= 0)
                  chk($sformatf("s%0d_ep%0d_gap", s, j), q[j].gap, vec[k].gap);
            end else begin
               chk($sformatf("s%0d_ep%0d_missing", s, j), q.size(), j + 1);
            end
            j++;
         end
      end
   endtask

   initial begin
      int nz;
      rst_n = 1'b0; start_ready = 1'b1; hold_a = 1'b0; hold_b = 1'b0;
      skip_a = 3'b000; skip_b = 2'b00; silent_a = 3'b000;
      busy_a = 3'b000; busy_b = 2'b00; en_last_a = 3'b000; en_last_b = 2'b00;
      dc_a = 3'b101; dc_b = 2'b10;
      for (int i = 0; i < 3; i++) begin cnt_a[i] = 0; done_a[i] = 1'b0; end
      for (int i = 0; i < 2; i++) begin cnt_b[i] = 0; done_b[i] = 1'b0; end
      st_a = 0; st_b = 0; gap_a = 0; gap_b = 0; drop_a = 0; drop_b = 0;
      fdn_a = 0; fdn_b = 0; tx_c1_a = 0;

      // {scenario, enable pattern, cycles high, low cycles before it (-1 = don't care)}
      vec = '{
         '{1, 3'b001, 7, -1}, '{1, 3'b010, 7, 2}, '{1, 3'b100, 7, 2},
         '{1, 3'b010, 7, 2},  '{1, 3'b100, 7, 2},
         '{2, 3'b001, 7, -1}, '{2, 3'b010, 4, 2}, '{2, 3'b100, 7, 2}, '{2, 3'b010, 4, 2},
         '{3, 3'b001, 7, -1}, '{3, 3'b100, 7, 3}, '{3, 3'b100, 7, 3},
         '{4, 3'b001, 7, -1}, '{4, 3'b010, 7, 2},
         '{5, 3'b001, 7, -1}, '{5, 3'b010, 7, 2}
      };

      // 1: plain loop, two passes
      reset_all();
      wait_obs(1'b0, 5, "s1_timeout");
      repeat (3) step();
      check_eps(1, obs_a);
      chk("s1_frame_done_pulses", fdn_a, 2);
      chk("s1_frame_count", int'(fc_a), 2);

      // 2: client 1 never answers
      silent_a = 3'b010;
      reset_all();
      wait_obs(1'b0, 4, "s2_timeout");
      repeat (3) step();
      check_eps(2, obs_a);
      chk("s2_transmit_c1", tx_c1_a, 0);
      chk("s2_frame_count", int'(fc_a), 1);
      silent_a = 3'b000;

      // 3: client 1 skipped in the loop
      skip_a = 3'b010;
      reset_all();
      wait_obs(1'b0, 3, "s3_timeout");
      repeat (3) step();
      check_eps(3, obs_a);
      chk("s3_frame_done_pulses", fdn_a, 2);
      chk("s3_frame_count", int'(fc_a), 2);
      skip_a = 3'b000;

      // 4: hold between client 1 and client 2
      reset_all();
      wait_en_a(3'b010, "s4_c1_enabled");
      repeat (3) step();
      hold_a = 1'b1;
      wait_en_a(3'b000, "s4_c1_finished");
      nz = 0;
      repeat (10) begin
         step();
         if (ia.client_enable != 3'b000) nz++;
      end
      chk("s4_no_enable_in_hold", nz, 0);
      chk("s4_idx_in_hold", int'(idx_a), 2);
      hold_a = 1'b0;
      step();
      chk("s4_c2_after_release", int'(ia.client_enable), 4);
      check_eps(4, obs_a);

      // 5: one-shot only instance ends in DONE
      reset_all();
      wait_obs(1'b1, 2, "s5_timeout");
      repeat (30) step();
      check_eps(5, obs_b);
      chk("s5_episode_count", obs_b.size(), 2);
      chk("s5_frame_done_pulses", fdn_b, 1);
      chk("s5_enable_idle", int'(ib.client_enable), 0);
      chk("s5_frame_count", int'(fc_b), 0);

      // 6: async reset during the second client-2 run
      reset_all();
      wait_obs(1'b0, 4, "s6_timeout");
      wait_en_a(3'b100, "s6_c2_enabled");
      repeat (3) step();
      chk("s6_fc_before_reset", int'(fc_a), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("s6_rst_enable", int'(ia.client_enable), 0);
      chk("s6_rst_spi", int'({ia.spi_data, ia.spi_dc, ia.spi_transmit}), 0);
      chk("s6_rst_fc", int'(fc_a), 0);
      start_ready = 1'b0;
      #2;
      rst_n = 1'b1;
      nz = 0;
      repeat (5) begin
         step();
         if (ia.client_enable != 3'b000) nz++;
      end
      chk("s6_waits_start_ready", nz, 0);
      start_ready = 1'b1;
      step();
      step();
      chk("s6_restart_client0", int'(ia.client_enable), 1);
      chk("s6_restart_idx", int'(idx_a), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
